alu_result_serializer: RTL and testbench
========================================

// Module: alu_result_serializer
// PURPOSE
//  Transmit side for ALU results: accepts one 8-bit ALUOut word (e.g. 8'b00001111 from the
//  any-bit-set operation) over a valid/ready handshake and shifts it out on a 1-wire serial line.
//  Frame = start(0), data LSB-first, [parity], stop(1).
//  Sits between the ALU output register and an off-board/LED serial receiver.
//  Holds no queue: one word in flight at a time.
// PARAMETERS
//  DATA_W    8   payload width in bits (ALUOut width)
//  BAUD_DIV  4   clock cycles each serial bit is held on tx_out; legal range >= 1
// PORTS
//  clock     in   1       system clock, rising edge
//  resetn    in   1       asynchronous, active-low reset
//  in_valid  in   1       in_data holds a word to send
//  in_ready  out  1       block can accept a word this cycle
//  in_data   in   DATA_W  word to transmit, sampled on accept
//  tx_out    out  1       serial line, idles high
//  busy      out  1       frame in progress
//  done      out  1       one-cycle pulse when a frame completes
// BEHAVIOUR
//  Reset (resetn=0, async): state IDLE, tx_out=1, in_ready=1, busy=0, done=0,
//   shift reg=0, bit/baud counters=0. Reset mid-frame aborts the frame; no done pulse.
//  Accept: in_valid && in_ready at a rising edge latches in_data. in_valid while busy is ignored.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:   tx_out=1; in_ready=1; on accept -> START.
//   START:  tx_out=0 for BAUD_DIV cycles.
//   DATA:   tx_out=shift[0]; shift right every BAUD_DIV cycles; DATA_W bits total.
//   PARITY: present only when compiled in (see CONFIGURATION).
//   STOP:   tx_out=1 for BAUD_DIV cycles -> IDLE.
//  Latency: tx_out falls in the cycle immediately after the accept edge.
//  Baud counter counts 0..BAUD_DIV-1, wraps to 0 and advances the bit.
//  BAUD_DIV=1 gives one cycle per bit.
//  Frame length F = (DATA_W+2[+1]) * BAUD_DIV cycles.
//  done=1 for exactly the first IDLE cycle after STOP; in_ready is also 1 in that cycle.
//   A word presented then is accepted, giving back-to-back frames with a 1-cycle idle gap.
//  busy = (state != IDLE); in_ready = ~busy. All outputs are registered, with no combinational
//   path from inputs to outputs.
// CONFIGURATION
//  ALU_SER_PARITY_EN defined:
//   - adds PARITY state after DATA; tx_out = ^data (even parity) for BAUD_DIV cycles.
//   - frame = DATA_W+3 bits.
//  ALU_SER_PARITY_EN undefined:
//   - no PARITY state; DATA goes directly to STOP.
//   - frame = DATA_W+2 bits.
// STRUCTURE
//  Package alu_ser_pkg:
//   - state encoding localparams S_IDLE/S_START/S_DATA/S_PARITY/S_STOP;
//   - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
//  Sub-module baud_tick_gen (#BAUD_DIV):
//   - counter cleared by enable=0;
//   - outputs tick on the last cycle of each bit period.
//  Top level holds the FSM, shift register and bit counter.
// TESTING
//  1 Reset, BAUD_DIV=4, no parity; send 8'h0F.
//    -> tx_out bits 0,1,1,1,1,0,0,0,0,1, each held 4 cycles
//    -> done at cycle 41 after accept.
//  2 Hold in_valid=1 with 8'h00 then 8'hFF.
//    -> second accept occurs in the done cycle
//    -> exactly 1 idle-high cycle between frames.
//  3 Pulse in_valid with 8'hAA while busy.
//    -> ignored; current frame unchanged; no extra frame.
//  4 Assert resetn=0 during DATA bit 3.
//    -> tx_out=1 immediately (async); busy=0; no done; next send is a clean frame.
//  5 ALU_SER_PARITY_EN, BAUD_DIV=1.
//    -> 8'h07: parity bit 1, 11-cycle frame.
//    -> 8'h0F: parity bit 0.
//  6 BAUD_DIV=1, 8'h80.
//    -> line sequence 0,0,0,0,0,0,0,0,1,1; done at cycle 11.

Source files
------------

// File: rtl/alu_result_serializer_pkg.sv
// alu_ser_pkg: shared definitions for the ALU result serializer.
//   - state_e     : FSM state encoding (S_IDLE/S_START/S_DATA/S_PARITY/S_STOP)
//   - START_BIT, STOP_BIT, IDLE_LEVEL : serial line levels
//   - cnt_w()     : counter width helper that never returns zero
package alu_ser_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // A divide-by-1 counter still needs one bit of storage.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_result_serializer_baud_tick_gen.sv
// baud_tick_gen: bit-period timer for the serializer.
//   Counts 0..BAUD_DIV-1 while en_i is high and pulses tick_o on the last
//   cycle of each bit period. Dropping en_i clears the count, so every frame
//   starts with a full-length first bit.
// Ports:
//   clock   in  system clock, rising edge
//   resetn  in  asynchronous active-low reset
//   en_i    in  count enable (frame in progress)
//   tick_o  out last cycle of the current bit period
module baud_tick_gen
  import alu_ser_pkg::*;
#(
  parameter int BAUD_DIV = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = cnt_w(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: 1-wire transmitter for ALU result words.
//   Accepts one DATA_W word over valid/ready and sends
//   start(0), data LSB-first, [even parity], stop(1), each bit held BAUD_DIV
//   cycles. One word in flight; in_valid while busy is ignored.
//   Optional parity bit: define ALU_SER_PARITY_EN.
// Ports:
//   clock     in  system clock, rising edge
//   resetn    in  asynchronous active-low reset (aborts a frame, no done)
//   in_valid  in  in_data holds a word to send
//   in_ready  out block can accept a word this cycle (= ~busy)
//   in_data   in  word to send, sampled on accept
//   tx_out    out serial line, idles high
//   busy      out frame in progress
//   done      out one-cycle pulse in the first idle cycle after stop
// All outputs come straight from flops; tx/busy are computed from the
// next state so the line changes in the cycle right after the accept edge.
module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int            BW       = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;
  logic              accept;
`ifdef ALU_SER_PARITY_EN
  logic              par_q, par_d;
`endif

  baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clock  (clock),
    .resetn (resetn),
    .en_i   (busy_q),
    .tick_o (tick)
  );

  assign accept = in_valid && !busy_q;

  // Next state, shift register and bit counter.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
`ifdef ALU_SER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          shift_d = in_data;
          bit_d   = '0;
`ifdef ALU_SER_PARITY_EN
          // Captured up front since the shift register is consumed in DATA.
          par_d   = ^in_data;
`endif
        end
      end
      S_START: if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef ALU_SER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef ALU_SER_PARITY_EN
      S_PARITY: if (tick) state_d = S_STOP;
`endif
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, looked up from the next state.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_d)
      S_START:  tx_d = START_BIT;
      S_DATA:   tx_d = shift_d[0];
`ifdef ALU_SER_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      S_STOP:   tx_d = STOP_BIT;
      default:  tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef ALU_SER_PARITY_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) par_q <= 1'b0;
    else         par_q <= par_d;
  end
`endif

  assign tx_out   = tx_q;
  assign busy     = busy_q;
  assign in_ready = ~busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
module tb_alu_result_serializer;

`ifdef ALU_SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB = PAR_EN ? 11 : 10;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       v4 = 1'b0, v1 = 1'b0;
  logic [7:0] d4 = '0, d1 = '0;
  logic       rdy4, tx4, busy4, done4;
  logic       rdy1, tx1, busy1, done1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  alu_result_serializer #(.DATA_W(8), .BAUD_DIV(4)) u_b4 (
    .clock(clock), .resetn(resetn), .in_valid(v4), .in_ready(rdy4),
    .in_data(d4), .tx_out(tx4), .busy(busy4), .done(done4));

  alu_result_serializer #(.DATA_W(8), .BAUD_DIV(1)) u_b1 (
    .clock(clock), .resetn(resetn), .in_valid(v1), .in_ready(rdy1),
    .in_data(d1), .tx_out(tx1), .busy(busy1), .done(done1));

  typedef struct {
    int         which;  // 1 -> BAUD_DIV=1 instance, else BAUD_DIV=4
    logic [7:0] d;
    logic       par;    // hand-computed even parity
  } vec_t;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic g_tx(input int w);   return (w == 1) ? tx1   : tx4;   endfunction
  function automatic logic g_busy(input int w); return (w == 1) ? busy1 : busy4; endfunction
  function automatic logic g_done(input int w); return (w == 1) ? done1 : done4; endfunction
  function automatic logic g_rdy(input int w);  return (w == 1) ? rdy1  : rdy4;  endfunction

  // Expected line level for frame bit k (0 = start bit).
  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && PAR_EN) return p;
    return 1'b1;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [7:0] d);
    if (w == 1) begin v1 = v; d1 = d; end
    else        begin v4 = v; d4 = d; end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the accept.
  task automatic send(input int w, input logic [7:0] d, input string nm);
    chk({nm, " ready"}, g_rdy(w), 1'b1);
    set_in(w, 1'b1, d);
    @(posedge clock);
    @(negedge clock);
    set_in(w, 1'b0, 8'h00);
  endtask

  // Starts at the negedge of cycle 1; ends at the negedge of the done cycle.
  task automatic check_frame(input int w, input logic [7:0] d, input logic p, input string nm);
    int b;
    b = (w == 1) ? 1 : 4;
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < b; j++) begin
        chk($sformatf("%s bit%0d.%0d line", nm, k, j), g_tx(w), exp_bit(d, p, k));
        if (j == 0) begin
          chk($sformatf("%s bit%0d busy", nm, k), g_busy(w), 1'b1);
          chk($sformatf("%s bit%0d done", nm, k), g_done(w), 1'b0);
        end
        @(negedge clock);
      end
    end
    chk({nm, " done pulse"}, g_done(w), 1'b1);
    chk({nm, " ready at done"}, g_rdy(w), 1'b1);
    chk({nm, " idle line at done"}, g_tx(w), 1'b1);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{which: 4, d: 8'h0F, par: 1'b0};
    tbl[1] = '{which: 1, d: 8'h80, par: 1'b1};
    tbl[2] = '{which: 1, d: 8'h07, par: 1'b1};
    tbl[3] = '{which: 1, d: 8'h0F, par: 1'b0};
    tbl[4] = '{which: 4, d: 8'hA5, par: 1'b0};
    tbl[5] = '{which: 1, d: 8'h01, par: 1'b1};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst tx4", tx4, 1'b1);   chk("rst busy4", busy4, 1'b0);
    chk("rst rdy4", rdy4, 1'b1); chk("rst done4", done4, 1'b0);
    chk("rst tx1", tx1, 1'b1);   chk("rst rdy1", rdy1, 1'b1);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].which, tbl[i].d, $sformatf("vec%0d", i));
      check_frame(tbl[i].which, tbl[i].d, tbl[i].par, $sformatf("vec%0d", i));
      @(negedge clock);
      chk($sformatf("vec%0d done drops", i), g_done(tbl[i].which), 1'b0);
      chk($sformatf("vec%0d idle busy", i), g_busy(tbl[i].which), 1'b0);
      repeat (2) @(negedge clock);
    end

    // Back-to-back: in_valid held, second word accepted in the done cycle
    set_in(4, 1'b1, 8'h00);
    @(posedge clock);
    @(negedge clock);
    set_in(4, 1'b1, 8'hFF);
    check_frame(4, 8'h00, 1'b0, "b2b first");
    @(negedge clock);
    set_in(4, 1'b0, 8'h00);
    check_frame(4, 8'hFF, 1'b0, "b2b second");
    repeat (2) @(negedge clock);

    // in_valid pulsed while busy is ignored
    send(4, 8'h33, "ign");
    fork
      check_frame(4, 8'h33, 1'b0, "ign");
      begin
        repeat (10) @(negedge clock);
        set_in(4, 1'b1, 8'hAA);
        @(negedge clock);
        set_in(4, 1'b0, 8'h00);
      end
    join
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      chk($sformatf("ign no extra frame line c%0d", c), tx4, 1'b1);
      chk($sformatf("ign no extra frame busy c%0d", c), busy4, 1'b0);
    end

    // Async reset during data bit 3 (frame bit 4, cycles 17..20)
    send(4, 8'h55, "abort");
    repeat (17) @(negedge clock);
    chk("abort pre line", tx4, 1'b0);
    chk("abort pre busy", busy4, 1'b1);
    resetn = 1'b0;
    #1;
    chk("abort line high", tx4, 1'b1);
    chk("abort busy low", busy4, 1'b0);
    chk("abort ready", rdy4, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("abort no done c%0d", c), done4, 1'b0);
    end
    resetn = 1'b1;
    @(negedge clock);
    chk("abort post done", done4, 1'b0);
    send(4, 8'h0F, "post");
    check_frame(4, 8'h0F, 1'b0, "post");
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
